// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide owning HI/LO.
// One iteration per cycle for WIDTH cycles, then a sign-fix/write cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_op, r_neg_q, r_neg_r, r_dz, r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0] r_ma, r_mb, r_a, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic w_an, w_bn;
  logic [WIDTH-1:0] w_ma, w_mb, w_q, w_r;
  logic [WIDTH:0] w_sum, w_rsh, w_dif;
  logic [2*WIDTH-1:0] w_mstep, w_dstep, w_prod;
  assign w_an = is_signed & A[WIDTH-1];
  assign w_bn = is_signed & B[WIDTH-1];
  assign w_ma = w_an ? -A : A;
  assign w_mb = w_bn ? -B : B;
  // Multiply: acc = {partial product, remaining multiplier bits}
  assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_acc[0] ? r_ma : {WIDTH{1'b0}}};
  assign w_mstep = {w_sum, r_acc[WIDTH-1:1]};
  // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
  assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_dif   = w_rsh - {1'b0, r_mb};
  assign w_dstep = w_dif[WIDTH] ? {w_rsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                : {w_dif[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  always_comb begin
    w_next = r_state == S_IDLE ? (start ? S_CALC : S_IDLE)
           : r_state == S_CALC ? (r_cnt == CW'(WIDTH-1) ? S_FIX : S_CALC)
           : S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_op <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz <= 1'b0;
      r_ma <= '0;
      r_mb <= '0;
      r_a <= '0;
      r_acc <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= r_state == S_FIX;
      if (r_state == S_IDLE && start) begin
        r_op <= op;
        r_ma <= w_ma;
        r_mb <= w_mb;
        r_a <= A;
        r_neg_q <= w_an ^ w_bn;
        r_neg_r <= w_an;
        r_dz <= op && B == '0;
        r_acc <= {{WIDTH{1'b0}}, op ? w_ma : w_mb};
        r_cnt <= '0;
        r_busy <= 1'b1;
        r_div_zero <= 1'b0;
      end else if (r_state == S_IDLE) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op ? w_dstep : w_mstep;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_busy <= 1'b0;
        r_div_zero <= r_op && r_dz;
        r_hi <= !r_op ? w_prod[2*WIDTH-1:WIDTH] : r_dz ? r_a : w_r;
        r_lo <= !r_op ? w_prod[WIDTH-1:0] : r_dz ? {WIDTH{1'b1}} : w_q;
      end
    end
  end
  assign HI = r_hi;
  assign LO = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  assign div_zero = r_div_zero;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (HI/LO/div_zero per op).
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, op = 1'b0, is_signed = 1'b0;
  logic mthi = 1'b0, mtlo = 1'b0;
  logic [W-1:0] A = '0, B = '0, wdata = '0;
  logic [W-1:0] HI, LO;
  logic busy, done, div_zero;
  int total = 0, bad = 0;
  logic [2*W:0] sb[$];
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .is_signed(is_signed),
    .A(A), .B(B), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
  );
  task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference arithmetic in 64-bit so the signed overflow case is well defined
  function automatic logic [2*W:0] model(input logic o, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sbv, q, r;
    logic [63:0] p;
    if (!o) begin
      p = sg ? 64'($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b})) : {32'b0, a} * {32'b0, b};
      return {1'b0, p};
    end
    if (b == '0) return {1'b1, a, 32'hFFFFFFFF};
    sa  = sg ? {{W{a[W-1]}}, a} : {32'b0, a};
    sbv = sg ? {{W{b[W-1]}}, b} : {32'b0, b};
    q = sa / sbv;
    r = sa % sbv;
    return {1'b0, r[W-1:0], q[W-1:0]};
  endfunction
  task automatic launch(input logic o, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W:0] exp);
    op = o; is_signed = sg; A = a; B = b; start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_e0", {64'b0, busy}, 1);
  endtask
  task automatic wait_done(input int n0, input string tag);
    int n;
    logic early;
    logic [2*W:0] e;
    n = n0;
    early = 1'b0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (!done && !busy) early = 1'b1;
    end while (!done && n < 80);
    check({tag, "_lat"}, n, 33);
    check({tag, "_busy_gap"}, {64'b0, early}, 0);
    check({tag, "_busy_done"}, {64'b0, busy}, 0);
    e = sb.pop_front();
    check({tag, "_hi"}, {33'b0, HI}, {33'b0, e[2*W-1:W]});
    check({tag, "_lo"}, {33'b0, LO}, {33'b0, e[W-1:0]});
    check({tag, "_dz"}, {64'b0, div_zero}, {64'b0, e[2*W]});
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    logic ro, rs;
    #3;
    check("rst_hilo", {1'b0, HI, LO}, 0);
    check("rst_flags", {62'b0, busy, done, div_zero}, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;
    launch(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001});
    wait_done(0, "umul_max");
    launch(0, 1, 32'hFFFFFFFD, 32'd7, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_done(0, "smul_neg");
    launch(0, 0, 32'hFFFFFFFD, 32'd7, {1'b0, 32'h00000006, 32'hFFFFFFEB});
    wait_done(0, "umul_big");
    launch(1, 1, 32'hFFFFFFF9, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done(0, "sdiv_neg");
    launch(1, 0, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14});
    wait_done(0, "udiv");
    launch(1, 1, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000});
    wait_done(0, "sdiv_ovf");
    launch(1, 0, 32'h12345678, 32'h0, {1'b1, 32'h12345678, 32'hFFFFFFFF});
    wait_done(0, "div0");
    launch(0, 0, 32'd2, 32'd3, {1'b0, 32'h0, 32'd6});
    wait_done(0, "dz_clear");
    mthi = 1'b1; wdata = 32'hAAAA0000;
    @(posedge clk) #1 mthi = 1'b0;
    check("mthi", {33'b0, HI}, {33'b0, 32'hAAAA0000});
    check("mthi_lo", {33'b0, LO}, {33'b0, 32'd6});
    mtlo = 1'b1; wdata = 32'h00005555;
    @(posedge clk) #1 mtlo = 1'b0;
    check("mtlo", {1'b0, HI, LO}, {1'b0, 32'hAAAA0000, 32'h00005555});
    check("mt_nodone", {64'b0, done}, 0);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h13572468;
    @(posedge clk) #1 begin mthi = 1'b0; mtlo = 1'b0; end
    check("mt_both", {1'b0, HI, LO}, {1'b0, 32'h13572468, 32'h13572468});
    launch(0, 0, 32'h12345678, 32'h100, {1'b0, 32'h12, 32'h34567800});
    repeat (5) @(posedge clk);
    #1 begin mthi = 1'b1; wdata = 32'hDEAD0000; start = 1'b1; op = 1'b1; A = 32'd9; B = 32'd4; end
    @(posedge clk) #1 begin mthi = 1'b0; start = 1'b0; end
    wait_done(6, "ign_busy");
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      ro = i[0]; rs = i[1];
      launch(ro, rs, ra, rb, model(ro, rs, ra, rb));
      wait_done(0, "rand");
    end
    launch(0, 0, 32'd5, 32'd6, {1'b0, 32'd0, 32'd30});
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_hilo", {1'b0, HI, LO}, 0);
    check("arst_busy", {63'b0, busy, done}, 0);
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("arst_nodone", {63'b0, done, busy}, 0);
    launch(0, 1, 32'hFFFFFFFE, 32'd3, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA});
    wait_done(0, "post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers for the MIPS-style datapath.
- Sits beside the ALU. It takes over the multiply and divide opcodes with a multi-cycle shift-add / restoring-divide engine, so the single-cycle ALU path no longer needs combinational 32x32 hardware.
- The HI/LO registers drive the MFHI/MFLO path.
- The core stalls on busy; done marks the HI/LO update.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned
- A  input  WIDTH  multiplicand / dividend
- B  input  WIDTH  multiplier / divisor
- mthi  input  1  write wdata to HI (MTHI)
- mtlo  input  1  write wdata to LO (MTLO)
- wdata  input  WIDTH  MTHI/MTLO data
- HI  output  WIDTH  HI register (product high / remainder)
- LO  output  WIDTH  LO register (product low / quotient)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, HI/LO just updated by an operation
- div_zero  output  1  registered; set by divide with B == 0, cleared by next accepted start

Behaviour:
- Reset: the asynchronous assert of reset_n = 0 forces state IDLE, HI = 0, LO = 0, busy = 0, done = 0, div_zero = 0, iteration counter = 0. This applies immediately, including mid-operation; the partial result is discarded.
- States:
  - IDLE: start = 1 at edge E0 latches op, is_signed, |A|, |B| and the result-sign flags, then moves to CALC with counter = 0. busy = 1 from E0.
  - CALC: one iteration per edge. Multiply: shift-add over the 2*WIDTH accumulator. Divide: restoring shift-subtract producing quotient and remainder magnitudes. At counter == WIDTH-1 go to FIX.
  - FIX, one cycle, edge E0+WIDTH+1: apply sign correction and write HI/LO. Next state IDLE; busy drops; done = 1 for exactly the following cycle.
- Latency: start edge to HI/LO valid = WIDTH+1 edges (33 for WIDTH = 32). Back-to-back start is accepted in the cycle done is high.
- Magnitudes: when is_signed = 1, negative operands are negated before CALC. Unsigned operands are used as-is.
- Multiply result: {HI, LO} = 2*WIDTH-bit product. It is negated in FIX if is_signed and exactly one operand is negative.
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero: negate if operand signs differ.
  - Signed remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed gives LO = 0x80000000, HI = 0 with no flag.
- Divide by zero (B == 0, checked at start): iterations still run and latency is unchanged. FIX writes LO = all ones and HI = original A, with no sign correction, and sets div_zero = 1.
- start while busy: ignored; latched operands are unaffected.
- mthi/mtlo in IDLE: write on the edge; both may assert in the same cycle.
- mthi/mtlo while busy: ignored. No done pulse results from MT writes.
- HI/LO hold their value except on a FIX write or an IDLE MT write.
- If mthi/mtlo and start are both asserted in IDLE, the MT write is ignored and the operation wins.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, then unsigned mult A = 0xFFFFFFFF, B = 0xFFFFFFFF -> done pulses exactly 33 edges after start; HI = 0xFFFFFFFE, LO = 0x00000001; busy high across 33 cycles.
- Signed mult A = -3 (0xFFFFFFFD), B = 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. The same operands unsigned -> HI = 0x00000006, LO = 0xFFFFFFEB.
- Signed div A = -7, B = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Unsigned div A = 100, B = 7 -> LO = 14, HI = 2.
  - Signed 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Div A = 0x12345678, B = 0 -> div_zero = 1, LO = 0xFFFFFFFF, HI = 0x12345678. A following mult 2 * 3 -> div_zero cleared, LO = 6, HI = 0.
- MTHI 0xAAAA0000 and MTLO 0x5555 in IDLE -> HI/LO updated next edge.
  - Start a mult, then pulse mthi and a second start mid-operation -> both ignored; the final HI/LO equal the first mult's product.
- Drop reset_n at CALC iteration 10 -> HI = LO = 0, busy = 0 immediately, no done pulse. A new start afterwards completes correctly in 33 cycles.
